avmm_burst_responder_ram: RTL and testbench
===========================================

// Module: avmm_burst_responder_ram
// PURPOSE
//  Avalon-MM burst responder (slave) terminating the mm_clock_crossing_bridge_0_m0 master port of C5G_QSYS.
//  Provides a 32-bit on-chip RAM window reached through the bridge; accepts pipelined read/write bursts.
//  Sits in the top level beside the Qsys instance, in the bridge's m0 clock domain.
// PARAMETERS
//  MEM_AW     10  RAM word-address width; depth = 2**MEM_AW 32-bit words
//  BURST_W    4   burstcount width, matches bridge m0 (max burst 2**BURST_W-1)
// PORTS
//  clk_clk            in   1        single clock, all logic rising-edge
//  reset_reset        in   1        synchronous, active-high reset
//  avs_address        in   29       byte address; word index = avs_address[MEM_AW+1:2], upper bits ignored (alias)
//  avs_burstcount     in   BURST_W  beats in burst, sampled on first accepted beat only
//  avs_writedata      in   32       write data
//  avs_byteenable     in   4        per-byte write enable
//  avs_write          in   1        write request
//  avs_read           in   1        read request
//  avs_debugaccess    in   1        accepted and ignored
//  avs_waitrequest    out  1        1 = command not accepted this cycle
//  avs_readdata       out  32       read beat data
//  avs_readdatavalid  out  1        1 = avs_readdata holds a valid beat
//  err_illegal        out  1        sticky: read+write together, or read during write burst
// BEHAVIOUR
//  Reset: state IDLE, avs_waitrequest=1 while reset_reset=1, avs_readdatavalid=0, avs_readdata=0, err_illegal=0.
//   RAM contents not cleared. Reset mid-burst aborts: no further readdatavalid after the reset edge.
//  FSM IDLE / WR_BURST / RD_BURST (/ RD_DRAIN with AVS_READ_PIPE_EN).
//  waitrequest = 0 in IDLE and WR_BURST, 1 in RD_BURST/RD_DRAIN and during reset (combinational from state).
//  burstcount 0 treated as 1. Beat address = base + beat index, wraps modulo 2**MEM_AW.
//  IDLE, write&!wait at T: beat0 written at T edge; burstcount==1 -> stay IDLE, else WR_BURST, remaining=N-1.
//  WR_BURST: each cycle with avs_write=1 writes next beat; avs_write=0 idles, no timeout.
//   Last beat -> IDLE; next command accepted the following cycle.
//  Byte lane b written only when byteenable[b]=1; byteenable=0 beat still consumes a beat.
//  IDLE, read&!wait at T: capture base, N; RD_BURST. Beats k=0..N-1 valid on cycles T+1+k (sync RAM, latency 1).
//   waitrequest=1 on T+1..T+N; IDLE (wait=0) at T+N+1. Back-to-back reads: gap of one cycle minimum.
//  readdatavalid strictly consecutive within a burst; never asserted outside a read burst.
//  Read+write same cycle in IDLE: write wins, read dropped, err_illegal<=1.
//  Read in WR_BURST: ignored, err_illegal<=1. Write to an address during its own read burst impossible (wait=1).
//  err_illegal clears only on reset.
// CONFIGURATION
//  AVS_READ_PIPE_EN defined: registered RAM output stage; beat k valid at T+2+k; RD_DRAIN holds waitrequest=1
//   through T+N+1; IDLE at T+N+2. Undefined: latency 1 as above, no RD_DRAIN state.
// TESTING
//  Single write 0xDEADBEEF @0x10, be=1111, then single read @0x10 -> waitrequest low at accept, readdatavalid at T+1, data 0xDEADBEEF.
//  Write burst N=8 @0x0 data 1..8 with write deasserted 2 cycles after beat 3 -> read burst N=8 returns 1..8 on 8 consecutive cycles, wait=1 T+1..T+8.
//  Byteenable 0101 writing 0xAABBCCDD over 0x11223344 -> read returns 0x11BB33DD.
//  Burst N=4 starting at last word (2**MEM_AW-1) -> beats 1..3 land at words 0,1,2 (wrap).
//  Read N=8, assert reset_reset at beat 3 -> readdatavalid 0 from next cycle, waitrequest 1 during reset, 0 after; RAM data intact.
//  read+write same cycle -> write performed, no readdatavalid, err_illegal=1 until reset; repeat all with AVS_READ_PIPE_EN (latency +1).

Source files
------------

// File: rtl/avmm_burst_responder_ram.sv
// Avalon-MM burst responder backed by a 2**MEM_AW x 32-bit on-chip RAM (IDLE / WR_BURST / RD_BURST).
// Optional macro AVS_READ_PIPE_EN adds a registered read-output stage and an RD_DRAIN state (+1 read latency).
module avmm_burst_responder_ram #(
    parameter int MEM_AW  = 10,
    parameter int BURST_W = 4
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [28:0]        avs_address,
    input  logic [BURST_W-1:0] avs_burstcount,
    input  logic [31:0]        avs_writedata,
    input  logic [3:0]         avs_byteenable,
    input  logic               avs_write,
    input  logic               avs_read,
    input  logic               avs_debugaccess,
    output logic               avs_waitrequest,
    output logic [31:0]        avs_readdata,
    output logic               avs_readdatavalid,
    output logic               err_illegal
);

`ifdef AVS_READ_PIPE_EN
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, RD_DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;
`endif

    state_t             state;
    logic [31:0]        mem [0:(1<<MEM_AW)-1];
    logic [MEM_AW-1:0]  word_addr;
    logic [MEM_AW-1:0]  wr_addr;
    logic [MEM_AW-1:0]  rd_addr;
    logic [MEM_AW-1:0]  wr_index;
    logic [BURST_W-1:0] burst_len;
    logic [BURST_W-1:0] remaining;
    logic [31:0]        beat_data;
    logic               beat_valid;
    logic               wr_en;
    logic               unused_ok;

    // Handshake: a read or write beat is taken on a rising edge where it is asserted and
    // avs_waitrequest is low; read beats come back one per cycle under avs_readdatavalid, no backpressure.
    assign word_addr       = avs_address[MEM_AW+1:2];
    assign burst_len       = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;
    assign avs_waitrequest = reset_reset || (state != IDLE && state != WR_BURST);
    assign wr_en           = !reset_reset && avs_write && (state == IDLE || state == WR_BURST);
    assign wr_index        = (state == IDLE) ? word_addr : wr_addr;
    assign unused_ok       = ^{avs_debugaccess, avs_address[28:MEM_AW+2], avs_address[1:0]};

    // RAM contents survive reset; only byte lanes with byteenable set are updated.
    always_ff @(posedge clk_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b]) begin
                    mem[wr_index][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= IDLE;
            wr_addr     <= '0;
            rd_addr     <= '0;
            remaining   <= '0;
            beat_data   <= '0;
            beat_valid  <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            beat_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (avs_write) begin
                        if (avs_read) begin
                            err_illegal <= 1'b1;
                        end
                        if (burst_len != BURST_W'(1)) begin
                            state     <= WR_BURST;
                            wr_addr   <= word_addr + 1'b1;
                            remaining <= burst_len - 1'b1;
                        end
                    end else if (avs_read) begin
                        beat_data  <= mem[word_addr];
                        beat_valid <= 1'b1;
                        rd_addr    <= word_addr + 1'b1;
                        remaining  <= burst_len - 1'b1;
                        state      <= RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (avs_read) begin
                        err_illegal <= 1'b1;
                    end
                    if (avs_write) begin
                        wr_addr   <= wr_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == BURST_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    if (remaining != '0) begin
                        beat_data  <= mem[rd_addr];
                        beat_valid <= 1'b1;
                        rd_addr    <= rd_addr + 1'b1;
                        remaining  <= remaining - 1'b1;
                    end else begin
`ifdef AVS_READ_PIPE_EN
                        state <= RD_DRAIN;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef AVS_READ_PIPE_EN
                RD_DRAIN: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AVS_READ_PIPE_EN
    // Output register stage; cleared by reset so an aborted burst emits nothing further.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdata      <= beat_data;
            avs_readdatavalid <= beat_valid;
        end
    end
`else
    assign avs_readdata      = beat_data;
    assign avs_readdatavalid = beat_valid;
`endif

endmodule

// File: tb/tb_avmm_burst_responder_ram.sv
// Bench for avmm_burst_responder_ram: cycle-scheduled behavioural model plus directed literal scenarios.
// Build with AVS_READ_PIPE_EN defined to check the pipelined read variant.
module tb_avmm_burst_responder_ram;
    localparam int MEM_AW  = 10;
    localparam int BURST_W = 4;
    localparam int DEPTH   = 1 << MEM_AW;
`ifdef AVS_READ_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic               clk_clk = 1'b0;
    logic               reset_reset;
    logic [28:0]        avs_address;
    logic [BURST_W-1:0] avs_burstcount;
    logic [31:0]        avs_writedata;
    logic [3:0]         avs_byteenable;
    logic               avs_write;
    logic               avs_read;
    logic               avs_debugaccess;
    logic               avs_waitrequest;
    logic [31:0]        avs_readdata;
    logic               avs_readdatavalid;
    logic               err_illegal;

    avmm_burst_responder_ram #(.MEM_AW(MEM_AW), .BURST_W(BURST_W)) dut (
        .clk_clk           (clk_clk),
        .reset_reset       (reset_reset),
        .avs_address       (avs_address),
        .avs_burstcount    (avs_burstcount),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_write         (avs_write),
        .avs_read          (avs_read),
        .avs_debugaccess   (avs_debugaccess),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .err_illegal       (err_illegal)
    );

    // Clock / cycle index: interval c is the time after posedge number c.
    always #5 clk_clk = ~clk_clk;
    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    // Behavioural model: RAM image plus per-cycle expectations.
    logic [31:0] model_mem [DEPTH];
    bit          exp_wait_at [int];
    bit          exp_err_at  [int];
    logic [31:0] exp_beat_at [int];
    int          m_rd_end  = -1;
    int          m_wr_left = 0;
    int          m_wr_ptr  = 0;
    bit          m_err     = 1'b0;
    bit          armed     = 1'b0;

    // Scoreboard for directed scenarios.
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          obs_cyc_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic void mem_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic model_cycle(input bit rst, input bit w, input bit r, input logic [28:0] a,
                               input logic [BURST_W-1:0] bc, input logic [31:0] d, input logic [3:0] be);
        int t;
        int n;
        int widx;
        int kill[$];
        t = cyc;
        if (rst) begin
            if (armed) begin
                exp_wait_at[t] = 1'b1;
                exp_err_at[t]  = m_err;
            end
            foreach (exp_beat_at[k]) if (k > t) kill.push_back(k);
            foreach (kill[i]) exp_beat_at.delete(kill[i]);
            m_rd_end  = t;
            m_wr_left = 0;
            m_err     = 1'b0;
            armed     = 1'b1;
            return;
        end
        exp_wait_at[t] = (t <= m_rd_end);
        exp_err_at[t]  = m_err;
        if (t <= m_rd_end) return;
        n    = (bc == 0) ? 1 : int'(bc);
        widx = int'(a[MEM_AW+1:2]);
        if (m_wr_left > 0) begin
            if (r) m_err = 1'b1;
            if (w) begin
                mem_write(m_wr_ptr, d, be);
                m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
                m_wr_left--;
            end
        end else if (w) begin
            if (r) m_err = 1'b1;
            mem_write(widx, d, be);
            m_wr_left = n - 1;
            m_wr_ptr  = (widx + 1) % DEPTH;
        end else if (r) begin
            for (int k = 0; k < n; k++) exp_beat_at[t + LAT + k] = model_mem[(widx + k) % DEPTH];
            m_rd_end = t + n + LAT - 1;
        end
    endtask

    // Driver tasks: called just after a rising edge, drive one cycle of inputs.
    task automatic drive(input bit w, input bit r, input logic [28:0] a, input logic [BURST_W-1:0] bc,
                         input logic [31:0] d, input logic [3:0] be);
        avs_write       = w;
        avs_read        = r;
        avs_address     = a;
        avs_burstcount  = bc;
        avs_writedata   = d;
        avs_byteenable  = be;
        avs_debugaccess = 1'($urandom);
        model_cycle(1'b0, w, r, a, bc, d, be);
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset_reset = 1'b1;
            avs_write   = 1'b0;
            avs_read    = 1'b0;
            model_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
            #2;
            check("rst_wait", 32'(avs_waitrequest), 32'd1);
            if (i > 0) begin
                check("rst_rdv", 32'(avs_readdatavalid), 32'd0);
                check("rst_rdata", avs_readdata, 32'd0);
                check("rst_err", 32'(err_illegal), 32'd0);
            end
            @(posedge clk_clk);
            #1;
        end
        reset_reset = 1'b0;
        #1;
    endtask

    task automatic check_burst(input string name, input int t_acc);
        check({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({name, "_data"}, obs_q[i], exp_q[i]);
            check({name, "_cycle"}, 32'(obs_cyc_q[i]), 32'(t_acc + LAT + i));
        end
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic clear_obs();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    // Compare process: every modelled cycle, checked away from the active edge.
    initial begin
        forever begin
            @(negedge clk_clk);
            if (exp_wait_at.exists(cyc)) begin
                check("wait", 32'(avs_waitrequest), 32'(exp_wait_at[cyc]));
                check("err", 32'(err_illegal), 32'(exp_err_at[cyc]));
                check("rdv", 32'(avs_readdatavalid), 32'(exp_beat_at.exists(cyc)));
                if (exp_beat_at.exists(cyc) && avs_readdatavalid === 1'b1)
                    check("rdata", avs_readdata, exp_beat_at[cyc]);
            end
            if (avs_readdatavalid === 1'b1) begin
                obs_q.push_back(avs_readdata);
                obs_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        int t_acc;
        bit w;
        bit r;
        reset_reset     = 1'b1;
        avs_write       = 1'b0;
        avs_read        = 1'b0;
        avs_address     = '0;
        avs_burstcount  = '0;
        avs_writedata   = '0;
        avs_byteenable  = '0;
        avs_debugaccess = 1'b0;
        do_reset(3);

        // Fill the whole RAM so every later read has a defined expectation.
        for (int b = 0; b < DEPTH / 8; b++) begin
            drive(1'b1, 1'b0, 29'(b * 32), 4'd8, $urandom, 4'hF);
            for (int k = 1; k < 8; k++) drive(1'b1, 1'b0, '0, '0, $urandom, 4'hF);
        end

        // Single write then single read.
        clear_obs();
        drive(1'b1, 1'b0, 29'h10, 4'd1, 32'hDEADBEEF, 4'hF);
        check("s1_accept_wait", 32'(avs_waitrequest), 32'd0);
        t_acc = cyc;
        drive(1'b0, 1'b1, 29'h10, 4'd1, '0, '0);
        idle(LAT + 1);
        exp_q.push_back(32'hDEADBEEF);
        check_burst("s1", t_acc);

        // Write burst of 8 with a two-cycle gap after beat 3, then read it back.
        drive(1'b1, 1'b0, 29'h0, 4'd8, 32'd1, 4'hF);
        drive(1'b1, 1'b0, '0, '0, 32'd2, 4'hF);
        drive(1'b1, 1'b0, '0, '0, 32'd3, 4'hF);
        idle(2);
        for (int k = 4; k <= 8; k++) drive(1'b1, 1'b0, '0, '0, 32'(k), 4'hF);
        clear_obs();
        t_acc = cyc;
        drive(1'b0, 1'b1, 29'h0, 4'd8, '0, '0);
        for (int i = 1; i < 8 + LAT; i++) begin
            check("s2_busy_wait", 32'(avs_waitrequest), 32'd1);
            idle(1);
        end
        check("s2_idle_wait", 32'(avs_waitrequest), 32'd0);
        idle(1);
        for (int k = 1; k <= 8; k++) exp_q.push_back(32'(k));
        check_burst("s2", t_acc);

        // Reset during beat 3 of a read burst aborts it; RAM keeps its data.
        clear_obs();
        t_acc = cyc;
        drive(1'b0, 1'b1, 29'h0, 4'd8, '0, '0);
        idle(LAT + 2);
        do_reset(2);
        check("s5_post_rst_wait", 32'(avs_waitrequest), 32'd0);
        idle(LAT + 10);
        for (int k = 1; k <= 4; k++) exp_q.push_back(32'(k));
        check_burst("s5_abort", t_acc);
        t_acc = cyc;
        drive(1'b0, 1'b1, 29'h0, 4'd8, '0, '0);
        idle(8 + LAT);
        for (int k = 1; k <= 8; k++) exp_q.push_back(32'(k));
        check_burst("s5_intact", t_acc);

        // Partial byte enables.
        drive(1'b1, 1'b0, 29'h50, 4'd1, 32'h11223344, 4'hF);
        drive(1'b1, 1'b0, 29'h50, 4'd1, 32'hAABBCCDD, 4'b0101);
        check("s3_model_pin", model_mem[20], 32'h11BB33DD);
        clear_obs();
        t_acc = cyc;
        drive(1'b0, 1'b1, 29'h50, 4'd0, '0, '0);
        idle(LAT + 1);
        exp_q.push_back(32'h11BB33DD);
        check_burst("s3", t_acc);

        // Burst starting at the last word wraps to word 0; upper address bits alias.
        drive(1'b1, 1'b0, 29'h1000_0FFC, 4'd4, 32'hA0, 4'hF);
        for (int k = 1; k < 4; k++) drive(1'b1, 1'b0, '0, '0, 32'hA0 + 32'(k), 4'hF);
        check("s4_model_pin", model_mem[0], 32'hA1);
        clear_obs();
        t_acc = cyc;
        drive(1'b0, 1'b1, 29'h0FFC, 4'd4, '0, '0);
        idle(4 + LAT);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'hA0 + 32'(k));
        check_burst("s4", t_acc);

        // Read and write together: write wins, no read beats, sticky error.
        clear_obs();
        drive(1'b1, 1'b1, 29'h80, 4'd1, 32'h5A5AA5A5, 4'hF);
        check("s6_err_set", 32'(err_illegal), 32'd1);
        idle(LAT + 3);
        check("s6_no_rdv", 32'(obs_q.size()), 32'd0);
        t_acc = cyc;
        drive(1'b0, 1'b1, 29'h80, 4'd1, '0, '0);
        idle(LAT + 1);
        exp_q.push_back(32'h5A5AA5A5);
        check_burst("s6", t_acc);
        check("s6_err_sticky", 32'(err_illegal), 32'd1);
        do_reset(1);
        check("s6_err_clear", 32'(err_illegal), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                w = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 3);
                if (w && r && $urandom_range(0, 19) != 0) r = 1'b0;
                if (m_wr_left > 0 && r && $urandom_range(0, 9) != 0) r = 1'b0;
                drive(w, r, 29'($urandom), 4'($urandom), $urandom, 4'($urandom));
            end
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
